// File: rtl/alu.sv
// Registered ALU selected by MIPS-style R-type function codes.
// Result and ADD/SUB status flags are computed combinationally and captured together on each rising edge.
module alu #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Data_A,
    input  logic [WIDTH-1:0] Data_B,
    input  logic [5:0]       Op,
    output logic [WIDTH-1:0] LEDS,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow
);

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    // Returns 1 when every bit of the truncated result is clear.
    function automatic logic is_zero(input logic [WIDTH-1:0] value);
        return ~(|value);
    endfunction

    // Returns 1 for two's-complement overflow, given the sign bits that
    // qualify the operation and the resulting sign.
    function automatic logic signed_ovf(
        input logic sign_a,
        input logic sign_b_eff,
        input logic sign_res
    );
        return (sign_a == sign_b_eff) && (sign_res != sign_a);
    endfunction

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             overflow_s;

    // Extra top bit holds the ADD carry-out and the SUB borrow.
    assign sum_s  = {1'b0, Data_A} + {1'b0, Data_B};
    assign diff_s = {1'b0, Data_A} - {1'b0, Data_B};

    // Operation decode; unknown opcodes yield a zero result with clear flags.
    always_comb begin
        result_s   = {WIDTH{1'b0}};
        carry_s    = 1'b0;
        overflow_s = 1'b0;
        case (Op)
            OP_ADD: begin
                result_s   = sum_s[WIDTH-1:0];
                carry_s    = sum_s[WIDTH];
                overflow_s = signed_ovf(Data_A[WIDTH-1], Data_B[WIDTH-1],
                                        sum_s[WIDTH-1]);
            end
            OP_SUB: begin
                result_s   = diff_s[WIDTH-1:0];
                carry_s    = diff_s[WIDTH];
                // Subtraction overflows when the operand signs differ, i.e.
                // when A and the negated B share a sign.
                overflow_s = signed_ovf(Data_A[WIDTH-1], ~Data_B[WIDTH-1],
                                        diff_s[WIDTH-1]);
            end
            OP_AND: result_s = Data_A & Data_B;
            OP_OR:  result_s = Data_A | Data_B;
            OP_XOR: result_s = Data_A ^ Data_B;
            OP_NOR: result_s = ~(Data_A | Data_B);
            OP_SRL: result_s = Data_A >> Data_B;
            // A signed shift fills with the sign bit, including for amounts >= WIDTH.
            OP_SRA: result_s = $signed(Data_A) >>> Data_B;
            default: begin
                result_s   = {WIDTH{1'b0}};
                carry_s    = 1'b0;
                overflow_s = 1'b0;
            end
        endcase
    end

    // Output registers: result and all flags are captured on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LEDS     <= {WIDTH{1'b0}};
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            LEDS     <= result_s;
            Zero     <= is_zero(result_s);
            Carry    <= carry_s;
            Overflow <= overflow_s;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu.
// Each feature task drives vectors and compares {LEDS,Zero,Carry,Overflow} one edge later.
module tb_alu;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] UNK = 6'b000000;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] op;
        logic [8:0] exp;   // {leds, zero, carry, overflow}
        string      name;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] Data_A;
    logic [5:0] Data_B;
    logic [5:0] Op;
    logic [5:0] LEDS;
    logic       Zero;
    logic       Carry;
    logic       Overflow;

    int checks;
    int failures;

    alu #(.WIDTH(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Data_A   (Data_A),
        .Data_B   (Data_B),
        .Op       (Op),
        .LEDS     (LEDS),
        .Zero     (Zero),
        .Carry    (Carry),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation and waits until just after the sampling edge.
    task automatic drive(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op);
        Data_A = a;
        Data_B = b;
        Op     = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        Data_A = 6'd15;
        Data_B = 6'd20;
        Op     = ADD;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({LEDS, Zero, Carry, Overflow} !== 9'b000000_0_0_0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {LEDS, Zero, Carry, Overflow}, 9'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        vec_t vs[$];
        vs.push_back('{6'd15, 6'd20, ADD, {6'h23, 1'b0, 1'b0, 1'b1}, "add_15_20"});
        vs.push_back('{6'd40, 6'd40, ADD, {6'h10, 1'b0, 1'b1, 1'b1}, "add_40_40"});
        vs.push_back('{6'h3F, 6'h01, ADD, {6'h00, 1'b1, 1'b1, 1'b0}, "add_wrap_zero"});
        foreach (vs[i]) begin
            drive(vs[i].a, vs[i].b, vs[i].op);
            checks++;
            if ({LEDS, Zero, Carry, Overflow} !== vs[i].exp) begin
                failures++;
                $display("FAIL %s got=%b exp=%b", vs[i].name, {LEDS, Zero, Carry, Overflow}, vs[i].exp);
            end
        end
    endtask

    task automatic test_sub();
        vec_t vs[$];
        vs.push_back('{6'd20, 6'd15, SUB, {6'h05, 1'b0, 1'b0, 1'b0}, "sub_20_15"});
        vs.push_back('{6'd15, 6'd20, SUB, {6'h3B, 1'b0, 1'b1, 1'b0}, "sub_15_20"});
        vs.push_back('{6'd9,  6'd9,  SUB, {6'h00, 1'b1, 1'b0, 1'b0}, "sub_equal"});
        // 31 - (-32): signs differ and the result goes negative.
        vs.push_back('{6'h1F, 6'h20, SUB, {6'h3F, 1'b0, 1'b1, 1'b1}, "sub_ovf"});
        foreach (vs[i]) begin
            drive(vs[i].a, vs[i].b, vs[i].op);
            checks++;
            if ({LEDS, Zero, Carry, Overflow} !== vs[i].exp) begin
                failures++;
                $display("FAIL %s got=%b exp=%b", vs[i].name, {LEDS, Zero, Carry, Overflow}, vs[i].exp);
            end
        end
    endtask

    task automatic test_logic();
        vec_t vs[$];
        vs.push_back('{6'd15, 6'd20, AND, {6'h04, 1'b0, 1'b0, 1'b0}, "and"});
        vs.push_back('{6'd15, 6'd20, OR,  {6'h1F, 1'b0, 1'b0, 1'b0}, "or"});
        vs.push_back('{6'd15, 6'd20, XOR, {6'h1B, 1'b0, 1'b0, 1'b0}, "xor"});
        vs.push_back('{6'd15, 6'd20, NOR, {6'h20, 1'b0, 1'b0, 1'b0}, "nor"});
        vs.push_back('{6'h2A, 6'h2A, XOR, {6'h00, 1'b1, 1'b0, 1'b0}, "xor_zero"});
        foreach (vs[i]) begin
            drive(vs[i].a, vs[i].b, vs[i].op);
            checks++;
            if ({LEDS, Zero, Carry, Overflow} !== vs[i].exp) begin
                failures++;
                $display("FAIL %s got=%b exp=%b", vs[i].name, {LEDS, Zero, Carry, Overflow}, vs[i].exp);
            end
        end
    endtask

    task automatic test_shift();
        vec_t vs[$];
        vs.push_back('{6'd15, 6'd3, SRL, {6'h01, 1'b0, 1'b0, 1'b0}, "srl_15_3"});
        vs.push_back('{6'd20, 6'd3, SRA, {6'h02, 1'b0, 1'b0, 1'b0}, "sra_20_3"});
        vs.push_back('{6'h28, 6'd3, SRA, {6'h3D, 1'b0, 1'b0, 1'b0}, "sra_neg_3"});
        vs.push_back('{6'h3F, 6'd7, SRL, {6'h00, 1'b1, 1'b0, 1'b0}, "srl_big"});
        vs.push_back('{6'h20, 6'd7, SRA, {6'h3F, 1'b0, 1'b0, 1'b0}, "sra_big"});
        vs.push_back('{6'h2D, 6'd0, SRA, {6'h2D, 1'b0, 1'b0, 1'b0}, "sra_zero_amt"});
        vs.push_back('{6'h2D, 6'd0, SRL, {6'h2D, 1'b0, 1'b0, 1'b0}, "srl_zero_amt"});
        vs.push_back('{6'h2D, 6'd6, SRL, {6'h00, 1'b1, 1'b0, 1'b0}, "srl_width"});
        foreach (vs[i]) begin
            drive(vs[i].a, vs[i].b, vs[i].op);
            checks++;
            if ({LEDS, Zero, Carry, Overflow} !== vs[i].exp) begin
                failures++;
                $display("FAIL %s got=%b exp=%b", vs[i].name, {LEDS, Zero, Carry, Overflow}, vs[i].exp);
            end
        end
    endtask

    task automatic test_unknown();
        vec_t vs[$];
        vs.push_back('{6'd15, 6'd20, UNK,      {6'h00, 1'b1, 1'b0, 1'b0}, "unknown_000000"});
        vs.push_back('{6'd40, 6'd40, 6'b100001, {6'h00, 1'b1, 1'b0, 1'b0}, "unknown_100001"});
        foreach (vs[i]) begin
            drive(vs[i].a, vs[i].b, vs[i].op);
            checks++;
            if ({LEDS, Zero, Carry, Overflow} !== vs[i].exp) begin
                failures++;
                $display("FAIL %s got=%b exp=%b", vs[i].name, {LEDS, Zero, Carry, Overflow}, vs[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Input changes between edges must not reach the outputs before the next edge.
        drive(6'd20, 6'd15, SUB);
        Data_A = 6'd40;
        Data_B = 6'd40;
        Op     = ADD;
        #3;
        checks++;
        if ({LEDS, Zero, Carry, Overflow} !== {6'h05, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL hold_between_edges got=%b exp=%b", {LEDS, Zero, Carry, Overflow}, {6'h05, 3'b000});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({LEDS, Zero, Carry, Overflow} !== {6'h10, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL b2b_add got=%b exp=%b", {LEDS, Zero, Carry, Overflow}, {6'h10, 3'b011});
        end
        drive(6'd15, 6'd20, NOR);
        checks++;
        if ({LEDS, Zero, Carry, Overflow} !== {6'h20, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_nor got=%b exp=%b", {LEDS, Zero, Carry, Overflow}, {6'h20, 3'b000});
        end
    endtask

    task automatic test_reset_midstream();
        drive(6'd15, 6'd20, ADD);
        checks++;
        if ({LEDS, Zero, Carry, Overflow} !== {6'h23, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL stream_before_reset got=%b exp=%b", {LEDS, Zero, Carry, Overflow}, {6'h23, 3'b001});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({LEDS, Zero, Carry, Overflow} !== 9'b0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", {LEDS, Zero, Carry, Overflow}, 9'b0);
        end
        Data_A = 6'd40;
        Data_B = 6'd40;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({LEDS, Zero, Carry, Overflow} !== 9'b0) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", {LEDS, Zero, Carry, Overflow}, 9'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({LEDS, Zero, Carry, Overflow} !== {6'h10, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL first_after_release got=%b exp=%b", {LEDS, Zero, Carry, Overflow}, {6'h10, 3'b011});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_unknown();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
